// File: rtl/rng_arbiter_pkg.sv
// Shared definitions for the rng arbiter: FSM encoding and parameter defaults.
package rng_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEED  = 2'd1,
        WARM  = 2'd2,
        SERVE = 2'd3
    } state_e;

    localparam int unsigned NREQ_DEFAULT   = 4;
    localparam int unsigned WARMUP_DEFAULT = 64;

endpackage

// File: rtl/rng_arbiter_rng.sv
// 32-bit xorshift generator. No reset: contents are meaningless until a seed
// is loaded. A zero seed locks the generator at zero.
module rng_arbiter_rng (
    input  logic        clk,
    input  logic        loadseed_i,
    input  logic [31:0] seed_i,
    output logic [31:0] number_o
);

    logic [31:0] state_q, state_d;
    logic [31:0] x1, x2;

    // Next value: load the seed, otherwise advance one xorshift step.
    always_comb begin
        x1      = state_q ^ (state_q << 13);
        x2      = x1 ^ (x1 >> 17);
        state_d = loadseed_i ? seed_i : (x2 ^ (x2 << 5));
    end

    // Generator state register.
    always_ff @(posedge clk) begin
        state_q <= state_d;
    end

    assign number_o = state_q;

endmodule

// File: rtl/rng_arbiter.sv
// Shares one rng among NREQ requesters with round-robin grants, after a
// seed load and a WARMUP-cycle discard phase.
module rng_arbiter
    import rng_arbiter_pkg::*;
#(
    parameter int unsigned NREQ   = NREQ_DEFAULT,
    parameter int unsigned WARMUP = WARMUP_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [31:0]     seed_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [31:0]     number_o,
    output logic            valid_o,
    output logic            ready_o,
    output logic [15:0]     issued_o
);

    localparam int unsigned PW = $clog2(NREQ);

    state_e          state_q, state_d;
    logic [31:0]     seed_q, seed_d;
    logic [7:0]      warm_cnt_q, warm_cnt_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [31:0]     number_q, number_d;
    logic [15:0]     issued_q, issued_d;

    logic            loadseed;
    logic [31:0]     rng_num;
    logic            sel_valid;
    logic [PW-1:0]   sel_idx;
    logic [PW-1:0]   rr_idx;

    rng_arbiter_rng u_rng (
        .clk        (clk),
        .loadseed_i (loadseed),
        .seed_i     (seed_q),
        .number_o   (rng_num)
    );

    // Round-robin pick: first active request at or after the pointer.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        rr_idx    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            rr_idx = PW'((32'(ptr_q) + i) % NREQ);
            if (!sel_valid && req_i[rr_idx]) begin
                sel_valid = 1'b1;
                sel_idx   = rr_idx;
            end
        end
    end

    // FSM next state, seed capture, warm-up counting and grant generation.
    always_comb begin
        state_d    = state_q;
        seed_d     = seed_q;
        warm_cnt_d = warm_cnt_q;
        ptr_d      = ptr_q;
        gnt_d      = '0;
        number_d   = number_q;
        issued_d   = issued_q;
        loadseed   = 1'b0;
        case (state_q)
            IDLE, WARM, SERVE: begin
                if (start_i) begin
                    // Reseed wins over warm-up progress and any grant this cycle.
                    seed_d   = seed_i;
                    state_d  = SEED;
                    issued_d = '0;
                    ptr_d    = '0;
                end else if (state_q == WARM) begin
                    if (warm_cnt_q == 8'(WARMUP - 1)) begin
                        state_d = SERVE;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 8'd1;
                    end
                end else if (state_q == SERVE && sel_valid) begin
                    gnt_d[sel_idx] = 1'b1;
                    number_d       = rng_num;
                    issued_d       = issued_q + 16'd1;
                    ptr_d          = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
                end
            end
            SEED: begin
                loadseed   = 1'b1;
                warm_cnt_d = '0;
                ptr_d      = '0;
                state_d    = WARM;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            seed_q     <= '0;
            warm_cnt_q <= '0;
            ptr_q      <= '0;
            gnt_q      <= '0;
            number_q   <= '0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            seed_q     <= seed_d;
            warm_cnt_q <= warm_cnt_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            number_q   <= number_d;
            issued_q   <= issued_d;
        end
    end

    assign gnt_o    = gnt_q;
    assign valid_o  = |gnt_q;
    assign ready_o  = (state_q == SERVE);
    assign number_o = number_q;
    assign issued_o = issued_q;

endmodule

// File: tb/tb_rng_arbiter.sv
// Randomized bench for rng_arbiter against a cycle-count based reference model.
module tb_rng_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned WARMUP = 10;

    logic            clk     = 1'b0;
    logic            rst_n   = 1'b0;
    logic            start_i = 1'b0;
    logic [31:0]     seed_i  = '0;
    logic [NREQ-1:0] req_i   = '0;
    logic [NREQ-1:0] gnt_o;
    logic [31:0]     number_o;
    logic            valid_o;
    logic            ready_o;
    logic [15:0]     issued_o;

    rng_arbiter #(.NREQ(NREQ), .WARMUP(WARMUP)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (start_i),
        .seed_i   (seed_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .number_o (number_o),
        .valid_o  (valid_o),
        .ready_o  (ready_o),
        .issued_o (issued_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 30)
                $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: phase derived from edges elapsed since the accepted start.
    int unsigned     edge_n    = 0;
    bit              m_started = 1'b0;
    int unsigned     m_s       = 0;
    logic [31:0]     m_seed    = '0;
    logic [31:0]     m_rng     = '0;
    logic [NREQ-1:0] m_gnt     = '0;
    logic [31:0]     m_num     = '0;
    logic [15:0]     m_issued  = '0;
    int unsigned     m_ptr     = 0;

    logic [31:0] cap [$];

    function automatic logic [31:0] xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    task automatic compare_all();
        check_val("gnt", gnt_o, m_gnt);
        check_val("valid", valid_o, |m_gnt);
        check_val("number", number_o, m_num);
        check_val("ready", ready_o, m_started && (edge_n >= m_s + 1 + WARMUP));
        check_val("issued", issued_o, m_issued);
    endtask

    task automatic tick();
        bit          in_seed;
        bit          serving;
        bit          found;
        int unsigned k;
        @(posedge clk);
        edge_n++;
        in_seed = m_started && (edge_n == m_s + 1);
        serving = m_started && (edge_n >= m_s + 2 + WARMUP);
        m_gnt   = '0;
        found   = 1'b0;
        if (start_i && !in_seed) begin
            m_started = 1'b1;
            m_s       = edge_n;
            m_seed    = seed_i;
            m_issued  = '0;
            m_ptr     = 0;
        end else if (serving) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                k = (m_ptr + i) % NREQ;
                if (!found && req_i[k]) begin
                    found    = 1'b1;
                    m_gnt[k] = 1'b1;
                    m_num    = m_rng;
                    m_issued = m_issued + 16'd1;
                    m_ptr    = (k + 1) % NREQ;
                end
            end
        end
        m_rng = in_seed ? m_seed : xs(m_rng);
        #1;
        compare_all();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        m_started = 1'b0;
        m_gnt     = '0;
        m_num     = '0;
        m_issued  = '0;
        m_ptr     = 0;
        check_val("rst_gnt", gnt_o, 0);
        check_val("rst_valid", valid_o, 0);
        check_val("rst_ready", ready_o, 0);
        check_val("rst_number", number_o, 0);
        check_val("rst_issued", issued_o, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_seed(input logic [31:0] s);
        start_i = 1'b1;
        seed_i  = s;
        tick();
        start_i = 1'b0;
        seed_i  = $urandom;
        repeat (WARMUP) begin
            req_i = NREQ'($urandom);
            tick();
        end
        check_val("ready_before_end", ready_o, 0);
        tick();
        check_val("ready_after_warmup", ready_o, 1);
        req_i = '0;
    endtask

    task automatic collect(input int unsigned n);
        cap.delete();
        req_i = '1;
        for (int unsigned g = 0; g < n * 4 && cap.size() < n; g++) begin
            tick();
            if (valid_o) cap.push_back(number_o);
        end
        check_val("collect_count", cap.size(), n);
        req_i = '0;
    endtask

    initial begin
        logic [31:0] run_a [$];
        logic [31:0] run_b [$];
        int unsigned ndiff;

        apply_reset();

        // Nothing is served before a seed load completes.
        req_i = '1;
        repeat (5) tick();

        do_seed(32'h1);
        req_i = '1;
        for (int unsigned i = 0; i < 8; i++) begin
            tick();
            check_val("rr_seq", gnt_o, 32'(1) << (i % 4));
        end
        check_val("issued_after_8", issued_o, 8);

        // Idle requests: outputs hold.
        req_i = '0;
        repeat (3) tick();

        repeat (300) begin
            req_i = NREQ'($urandom);
            tick();
        end

        // Reseed in the same cycle as a request: grant suppressed.
        req_i = 4'b0001;
        tick();
        req_i   = 4'b0100;
        start_i = 1'b1;
        seed_i  = 32'h1234_5678;
        tick();
        start_i = 1'b0;
        check_val("abort_gnt", gnt_o, 0);
        check_val("abort_issued", issued_o, 0);
        repeat (1 + WARMUP) tick();
        req_i = '1;
        tick();
        check_val("ptr_after_reseed", gnt_o, 4'b0001);

        // A second start while seeding is ignored.
        start_i = 1'b1;
        seed_i  = 32'hA5A5_0F0F;
        tick();
        seed_i  = 32'h0BAD_0BAD;
        tick();
        start_i = 1'b0;
        repeat (WARMUP) tick();
        collect(12);

        // Reseed during warm-up restarts the warm-up.
        start_i = 1'b1;
        seed_i  = 32'h0000_0042;
        tick();
        start_i = 1'b0;
        repeat (4) tick();
        do_seed(32'h0000_9999);
        collect(12);

        // Same seed reproduces the sequence; a different seed does not.
        do_seed(32'hDEAD_BEEF);
        collect(16);
        run_a = cap;
        do_seed(32'hDEAD_BEEF);
        collect(16);
        run_b = cap;
        for (int unsigned i = 0; i < 16; i++)
            check_val("repeat_seed", run_b[i], run_a[i]);
        do_seed(32'h1);
        collect(16);
        ndiff = 0;
        for (int unsigned i = 0; i < 16; i++)
            if (cap[i] != run_a[i]) ndiff++;
        check_val("seed_differs", ndiff > 0, 1);

        // Reset in the middle of serving.
        do_seed(32'h7777_1111);
        req_i = 4'b0011;
        repeat (3) tick();
        apply_reset();
        req_i = 4'b0011;
        repeat (20) tick();
        do_seed(32'h3141_5926);
        req_i = 4'b0011;
        repeat (4) tick();

        // Issue counter wraps past 16'hFFFF.
        do_seed(32'h0000_0077);
        req_i = '1;
        repeat (65537) tick();
        check_val("issued_wrap", issued_o, 16'h0001);
        req_i = '0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
